load_ext_pipe: RTL and testbench
================================

// Module: load_ext_pipe
// PURPOSE
//  Registered load-data aligner/extender for the WB path, replacing the purely combinational extender.
//  Takes raw memory read data plus byte offset and load mode; produces the aligned, zero/sign-extended register value.
//  valid/ready handshake in and out; 2-entry (main + skid) buffer; 1-cycle latency; 1 result/cycle sustained.
//  Flags misaligned loads (AdEL) and counts them.
// PARAMETERS
//  DATA_W   32  data path width in bits; 32 or 64 only
//  TAG_W    5   width of destination tag carried alongside the data (register number)
//  CNT_W    16  width of the saturating misaligned-load counter
//  OFS_W = $clog2(DATA_W/8) is derived (localparam), not overridable
// PORTS
//  clk        in   1       clock, rising edge
//  reset_n    in   1       asynchronous reset, active low
//  flush      in   1       sync discard of all buffered results
//  in_valid   in   1       input beat valid
//  in_ready   out  1       block can accept a beat
//  in_ofs     in   OFS_W   byte offset of the load address within the word
//  in_rdata   in   DATA_W  raw memory read word
//  in_mode    in   3       000 full word, 001 lbu, 010 lb, 011 lhu, 100 lh, 101 lwl, 110 lwr, 111 lw32 (sign-ext)
//  in_old     in   DATA_W  current destination register value (lwl/lwr merge)
//  in_tag     in   TAG_W   destination tag
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer takes result
//  out_data   out  DATA_W  aligned/extended result
//  out_tag    out  TAG_W   tag of out_data
//  out_adel   out  1       result is a misaligned load; out_data forced 0
//  adel_cnt   out  CNT_W   saturating count of misaligned loads delivered
// BEHAVIOUR
//  Reset (async, reset_n=0): main/skid valid=0, out_data=0, out_tag=0, out_adel=0, adel_cnt=0; in_ready=1.
//  Extract: sh = in_rdata >> (8*in_ofs). Modes 000-100 as in the present extender, applied to sh.
//   000: sh; 001/010: sh[7:0] zero/sign-ext; 011/100: sh[15:0] zero/sign-ext to DATA_W.
//   111: sh[31:0] sign-ext to DATA_W (identical to 000 when DATA_W=32).
//  Alignment: 011/100 need in_ofs[0]=0; 111 needs in_ofs[1:0]=0; 000 needs in_ofs=0; bytes always aligned.
//   Misaligned -> out_adel=1, out_data=0, tag kept. 101/110 never misaligned.
//  Handshake: accept = in_valid & in_ready; deliver = out_valid & out_ready. in_ready = !skid_valid (registered).
//   out_valid = main_valid; out_* driven from main register only (no comb path in->out).
//   main empty or delivering: accept loads main; main full and not delivering: accept loads skid.
//   deliver with skid_valid: main <= skid, skid emptied (concurrent accept impossible, in_ready=0).
//   deliver with no accept and skid empty: main_valid <= 0.
//   out_* hold stable while out_valid & !out_ready.
//  flush: next edge main_valid=skid_valid=0; flush beats accept and deliver in same cycle; adel_cnt unchanged.
//  adel_cnt: +1 per deliver with out_adel=1; saturates at all-ones, no wrap.
//  Unknown DATA_W (not 32/64): elaboration error via generate block.
// CONFIGURATION
//  LOAD_EXT_LWLR_EN defined: modes 101/110 merge with in_old, low 32 bits, b=in_ofs[1:0]:
//   lwl: r = (in_rdata[31:0] << 8*(3-b)) | (in_old[31:0] & ~(32'hFFFFFFFF << 8*(3-b)))
//   lwr: r = (in_rdata[31:0] >> 8*b)     | (in_old[31:0] & ~(32'hFFFFFFFF >> 8*b))
//   DATA_W=64: upper 32 bits sign-extended from r[31].
//  Not defined: 101/110 behave as 000 (incl. alignment check); in_old unused.
// TESTING
//  Reset mid-stream with main+skid full -> out_valid=0, in_ready=1, adel_cnt=0 immediately.
//  DATA_W=32, rdata=32'h8899AABB, ofs=1, lb -> 32'hFFFFFFAA; lhu ofs=2 -> 32'h00008899; lh ofs=1 -> adel=1, data=0.
//  out_ready=0 for 3 cycles, 3 beats offered -> 2 accepted, in_ready=0; release -> results in order, 1 per cycle.
//  flush with both entries full and in_valid=1 -> next cycle out_valid=0, offered beat dropped, in_ready=1.
//  LWLR_EN, rdata=32'h11223344, old=32'hAABBCCDD, ofs=1: lwl -> 32'h3344CCDD; lwr -> 32'hAA112233.
//  CNT_W=2, 5 misaligned lh delivered -> adel_cnt=3 (saturated); DATA_W=64 lw32 of 32'h80000000 -> 64'hFFFFFFFF80000000.

Source files
------------

// File: rtl/load_ext_pipe_if.sv
// Load-extender handshake bundle: request beat in, aligned result out, plus the AdEL counter.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready follow the usual valid/ready rules; the slave side is the pipe.
interface load_ext_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
);
    localparam int OFS_W = $clog2(DATA_W/8);

    logic              in_valid;
    logic              in_ready;
    logic [OFS_W-1:0]  in_ofs;
    logic [DATA_W-1:0] in_rdata;
    logic [2:0]        in_mode;
    logic [DATA_W-1:0] in_old;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_adel;
    logic [CNT_W-1:0]  adel_cnt;

    modport master (
        output in_valid, in_ofs, in_rdata, in_mode, in_old, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_adel, adel_cnt
    );

    modport slave (
        input  in_valid, in_ofs, in_rdata, in_mode, in_old, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_adel, adel_cnt
    );
endinterface

// File: rtl/load_ext_pipe.sv
// Registered load-data aligner/extender with AdEL flagging and a saturating AdEL counter.
// Latency: 1 cycle, 1 result/cycle sustained; outputs come only from the main register.
// Backpressure: main + skid entries; in_ready = !skid_valid. LOAD_EXT_LWLR_EN enables lwl/lwr merging.
module load_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           flush,
    load_ext_pipe_if.slave bus
);
    localparam int OFS_W = $clog2(DATA_W/8);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("load_ext_pipe: DATA_W must be 32 or 64");
        end
    endgenerate

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] ext_dat;
    logic              ext_adel;

`ifdef LOAD_EXT_LWLR_EN
    logic [1:0]  b;
    logic [31:0] lwl_r;
    logic [31:0] lwr_r;

    assign b     = bus.in_ofs[1:0];
    assign lwl_r = (bus.in_rdata[31:0] << {2'd3 - b, 3'b000})
                 | (bus.in_old[31:0] & ~(32'hFFFF_FFFF << {2'd3 - b, 3'b000}));
    assign lwr_r = (bus.in_rdata[31:0] >> {b, 3'b000})
                 | (bus.in_old[31:0] & ~(32'hFFFF_FFFF >> {b, 3'b000}));
`else
    logic unused_old;
    assign unused_old = ^bus.in_old;
`endif

    always_comb begin
        sh       = bus.in_rdata >> {bus.in_ofs, 3'b000};
        ext_dat  = sh;
        ext_adel = 1'b0;
        case (bus.in_mode)
            3'b001: ext_dat = DATA_W'(sh[7:0]);
            3'b010: ext_dat = DATA_W'($signed(sh[7:0]));
            3'b011: begin
                ext_dat  = DATA_W'(sh[15:0]);
                ext_adel = bus.in_ofs[0];
            end
            3'b100: begin
                ext_dat  = DATA_W'($signed(sh[15:0]));
                ext_adel = bus.in_ofs[0];
            end
            3'b111: begin
                ext_dat  = DATA_W'($signed(sh[31:0]));
                ext_adel = |bus.in_ofs[1:0];
            end
`ifdef LOAD_EXT_LWLR_EN
            3'b101: ext_dat = DATA_W'($signed(lwl_r));
            3'b110: ext_dat = DATA_W'($signed(lwr_r));
`endif
            default: ext_adel = |bus.in_ofs;
        endcase
        if (ext_adel) begin
            ext_dat = '0;
        end
    end

    logic              main_vld, skid_vld;
    logic [DATA_W-1:0] main_dat, skid_dat;
    logic [TAG_W-1:0]  main_tag, skid_tag;
    logic              main_adel, skid_adel;
    logic [CNT_W-1:0]  adel_cnt;
    logic              accept, deliver;

    assign accept  = bus.in_valid & ~skid_vld;
    assign deliver = main_vld & bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            main_dat  <= '0;
            main_tag  <= '0;
            main_adel <= 1'b0;
            skid_dat  <= '0;
            skid_tag  <= '0;
            skid_adel <= 1'b0;
            adel_cnt  <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            if (deliver && main_adel && adel_cnt != '1) begin
                adel_cnt <= adel_cnt + CNT_W'(1);
            end
            if (accept && (!main_vld || deliver)) begin
                main_vld  <= 1'b1;
                main_dat  <= ext_dat;
                main_tag  <= bus.in_tag;
                main_adel <= ext_adel;
            end else if (accept) begin
                skid_vld  <= 1'b1;
                skid_dat  <= ext_dat;
                skid_tag  <= bus.in_tag;
                skid_adel <= ext_adel;
            end else if (deliver && skid_vld) begin
                // in_ready is low here, so no beat can race the skid promotion
                main_dat  <= skid_dat;
                main_tag  <= skid_tag;
                main_adel <= skid_adel;
                skid_vld  <= 1'b0;
            end else if (deliver) begin
                main_vld <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ~skid_vld;
    assign bus.out_valid = main_vld;
    assign bus.out_data  = main_dat;
    assign bus.out_tag   = main_tag;
    assign bus.out_adel  = main_adel;
    assign bus.adel_cnt  = adel_cnt;
endmodule

// File: tb/tb_load_ext_pipe.sv
// Scoreboard bench for load_ext_pipe: a 32-bit and a 64-bit (CNT_W=2) instance share stimulus.
module tb_load_ext_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    load_ext_pipe_if #(.DATA_W(32), .TAG_W(5), .CNT_W(16)) b32 ();
    load_ext_pipe_if #(.DATA_W(64), .TAG_W(5), .CNT_W(2))  b64 ();

    load_ext_pipe #(.DATA_W(32), .TAG_W(5), .CNT_W(16)) u32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32));
    load_ext_pipe #(.DATA_W(64), .TAG_W(5), .CNT_W(2)) u64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64));

    typedef struct {
        logic        adel;
        logic [63:0] dat;
        logic [4:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   cnt32 = 0;
    int   cnt64 = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shift, pick the field, extend, then apply the alignment rules.
    function automatic exp_t model(input logic [63:0] rd, input logic [63:0] old, input int ofs,
                                   input logic [2:0] mode, input int dw, input logic [4:0] tag);
        exp_t        e;
        logic [63:0] sh, v;
        logic [31:0] r, lo, om, ones;
        int          b;
        bit          mis;
        if (dw == 32) rd = rd & 64'hFFFF_FFFF;
        sh   = rd >> (8 * ofs);
        v    = sh;
        mis  = 1'b0;
        ones = '1;
        lo   = rd[31:0];
        om   = old[31:0];
        b    = ofs % 4;
        r    = '0;
        case (mode)
            3'd1: v = {56'd0, sh[7:0]};
            3'd2: v = {{56{sh[7]}}, sh[7:0]};
            3'd3: begin mis = (ofs % 2) != 0; v = {48'd0, sh[15:0]}; end
            3'd4: begin mis = (ofs % 2) != 0; v = {{48{sh[15]}}, sh[15:0]}; end
            3'd7: begin mis = (ofs % 4) != 0; v = {{32{sh[31]}}, sh[31:0]}; end
`ifdef LOAD_EXT_LWLR_EN
            3'd5: begin
                r = (lo << (8 * (3 - b))) | (om & ~(ones << (8 * (3 - b))));
                v = {{32{r[31]}}, r};
            end
            3'd6: begin
                r = (lo >> (8 * b)) | (om & ~(ones >> (8 * b)));
                v = {{32{r[31]}}, r};
            end
`endif
            default: mis = ofs != 0;
        endcase
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        if (mis) v = '0;
        e.adel = mis;
        e.dat  = v;
        e.tag  = tag;
        return e;
    endfunction

    // One cycle of stimulus, driven just after the falling edge.
    task automatic drive_cycle(input logic v, input logic [63:0] rd, input logic [63:0] old,
                               input logic [2:0] ofs, input logic [2:0] mode, input logic [4:0] tag,
                               input logic ordy, input logic fl);
        @(negedge clk);
        #1;
        chk("in_ready32", b32.in_ready, q32.size() < 2);
        chk("out_valid32", b32.out_valid, q32.size() != 0);
        chk("in_ready64", b64.in_ready, q64.size() < 2);
        chk("out_valid64", b64.out_valid, q64.size() != 0);
        b32.in_valid = v;   b64.in_valid = v;
        b32.in_rdata = rd[31:0]; b64.in_rdata = rd;
        b32.in_old = old[31:0];  b64.in_old = old;
        b32.in_ofs = ofs[1:0];   b64.in_ofs = ofs;
        b32.in_mode = mode; b64.in_mode = mode;
        b32.in_tag = tag;   b64.in_tag = tag;
        b32.out_ready = ordy; b64.out_ready = ordy;
        flush = fl;
        if (v && !fl && b32.in_ready) q32.push_back(model(rd, old, int'(ofs[1:0]), mode, 32, tag));
        if (v && !fl && b64.in_ready) q64.push_back(model(rd, old, int'(ofs), mode, 64, tag));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive_cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                        3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    endtask

    // Monitor: samples well before the rising edge, after the driver has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            chk("adel_cnt32", b32.adel_cnt, cnt32);
            chk("adel_cnt64", b64.adel_cnt, cnt64);
            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (b32.out_valid && b32.out_ready) begin
                    if (q32.size() == 0) begin
                        chk("unexpected32", 1, 0);
                    end else begin
                        e = q32.pop_front();
                        chk("data32", b32.out_data, e.dat);
                        chk("tag32", b32.out_tag, e.tag);
                        chk("adel32", b32.out_adel, e.adel);
                        if (e.adel && cnt32 < 65535) cnt32++;
                    end
                end
                if (b64.out_valid && b64.out_ready) begin
                    if (q64.size() == 0) begin
                        chk("unexpected64", 1, 0);
                    end else begin
                        e = q64.pop_front();
                        chk("data64", b64.out_data, e.dat);
                        chk("tag64", b64.out_tag, e.tag);
                        chk("adel64", b64.out_adel, e.adel);
                        if (e.adel && cnt64 < 3) cnt64++;
                    end
                end
            end
        end
    end

    initial begin
        b32.in_valid = 0; b64.in_valid = 0;
        b32.out_ready = 0; b64.out_ready = 0;
        b32.in_rdata = '0; b64.in_rdata = '0; b32.in_old = '0; b64.in_old = '0;
        b32.in_ofs = '0; b64.in_ofs = '0; b32.in_mode = '0; b64.in_mode = '0;
        b32.in_tag = '0; b64.in_tag = '0;
        #2;
        chk("rst_out_valid", b32.out_valid, 0);
        chk("rst_in_ready", b32.in_ready, 1);
        chk("rst_out_data", b32.out_data, 0);
        chk("rst_out_tag", b32.out_tag, 0);
        chk("rst_out_adel", b32.out_adel, 0);
        chk("rst_adel_cnt", b64.adel_cnt, 0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Extraction examples (64-bit instance sees a non-zero upper word)
        drive_cycle(1, 64'h01234567_8899AABB, '0, 3'd1, 3'b010, 5'd1, 1, 0);
        drive_cycle(1, 64'h01234567_8899AABB, '0, 3'd2, 3'b011, 5'd2, 1, 0);
        drive_cycle(1, 64'h01234567_8899AABB, '0, 3'd1, 3'b100, 5'd3, 1, 0);
        drive_cycle(1, 64'h11223344, 64'hAABBCCDD, 3'd1, 3'b101, 5'd4, 1, 0);
        drive_cycle(1, 64'h11223344, 64'hAABBCCDD, 3'd1, 3'b110, 5'd5, 1, 0);
        drive_cycle(1, 64'h80000000, '0, 3'd0, 3'b111, 5'd6, 1, 0);
        drive_cycle(1, 64'h80000000, '0, 3'd4, 3'b111, 5'd7, 1, 0);
        idle(3);

        // Stall: three beats offered, two fit, then drain in order
        for (int i = 0; i < 3; i++)
            drive_cycle(1, {$urandom, $urandom}, '0, 3'd0, 3'b001, 5'(10 + i), 0, 0);
        drive_cycle(0, '0, '0, '0, '0, '0, 0, 0);
        chk("stall_in_ready", b32.in_ready, 0);
        idle(4);

        // Flush with both entries full and a beat on offer
        drive_cycle(1, 64'h55, '0, 3'd0, 3'b000, 5'd20, 0, 0);
        drive_cycle(1, 64'h66, '0, 3'd0, 3'b000, 5'd21, 0, 0);
        drive_cycle(1, 64'h77, '0, 3'd0, 3'b000, 5'd22, 1, 1);
        idle(2);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++)
            drive_cycle(1, 64'hFFFF, '0, 3'd1, 3'b100, 5'(i), 1, 0);
        idle(3);
        chk("sat_adel_cnt64", b64.adel_cnt, 3);

        rand_cycles(600);

        // Asynchronous reset with both entries occupied
        for (int i = 0; i < 2; i++)
            drive_cycle(1, {$urandom, $urandom}, '0, 3'd1, 3'b011, 5'(i), 0, 0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        b32.in_valid = 0; b64.in_valid = 0;
        #1;
        chk("mid_rst_out_valid", b32.out_valid, 0);
        chk("mid_rst_in_ready", b32.in_ready, 1);
        chk("mid_rst_adel_cnt32", b32.adel_cnt, 0);
        chk("mid_rst_adel_cnt64", b64.adel_cnt, 0);
        q32.delete();
        q64.delete();
        cnt32 = 0;
        cnt64 = 0;
        @(negedge clk);
        #1 reset_n = 1'b1;

        rand_cycles(300);
        idle(6);
        chk("drain32", q32.size(), 0);
        chk("drain64", q64.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
